div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one sequential divider between two requesters
// Optional watchdog abort in WAIT enabled by defining DIV_ARB_WATCHDOG_EN (limit TMO cycles).
module div_arbiter #(
   parameter int W   = 8,
   parameter int TMO = 1023
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         div_start,
   output logic [W-1:0] div_a,
   output logic [W-1:0] div_b,
   input  logic         div_done,
   input  logic         div_zero,
   input  logic [W-1:0] div_q,
   input  logic [W-1:0] div_r,
   output logic         rsp_valid0,
   output logic         rsp_valid1,
   output logic [W-1:0] rsp_q,
   output logic [W-1:0] rsp_r,
   output logic         rsp_dz,
   output logic         rsp_err,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;
   logic   gnt;
   logic   last;
   logic   pick;

`ifdef DIV_ARB_WATCHDOG_EN
   localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);
   logic [CW-1:0] cnt;
`endif

   // On a tie the requester that was not served last wins.
   always_comb begin
      pick = 1'b0;
      if (req0 && req1)
         pick = ~last;
      else
         pick = req1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last       <= 1'b1;
         div_start  <= 1'b0;
         div_a      <= '0;
         div_b      <= '0;
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         rsp_q      <= '0;
         rsp_r      <= '0;
         rsp_dz     <= 1'b0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
`ifdef DIV_ARB_WATCHDOG_EN
         cnt        <= '0;
`endif
      end else begin
         div_start  <= 1'b0;
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt       <= pick;
                  div_a     <= pick ? a1 : a0;
                  div_b     <= pick ? b1 : b0;
                  div_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
`ifdef DIV_ARB_WATCHDOG_EN
               cnt   <= '0;
`endif
            end
            WAIT: begin
               if (div_done) begin
                  rsp_q      <= div_q;
                  rsp_r      <= div_r;
                  rsp_dz     <= div_zero;
                  rsp_err    <= 1'b0;
                  rsp_valid0 <= ~gnt;
                  rsp_valid1 <= gnt;
                  state      <= RESP;
               end
`ifdef DIV_ARB_WATCHDOG_EN
               // Counter reaching TMO on this edge means the divider is considered hung.
               else if (cnt == CW'(TMO - 1)) begin
                  rsp_q      <= '1;
                  rsp_r      <= '1;
                  rsp_dz     <= 1'b0;
                  rsp_err    <= 1'b1;
                  rsp_valid0 <= ~gnt;
                  rsp_valid1 <= gnt;
                  state      <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               last  <= gnt;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
